// File: rtl/fft_pkg.sv
// Shared FFT datapath types, default widths and fixed-point helpers.
// Helpers work on a 64-bit signed container wide enough for every intermediate.
package fft_pkg;

    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_TW    = 16;
    localparam int unsigned DEF_TFRAC = 8;
    localparam int unsigned ONE_Q     = 1 << DEF_TFRAC;

    typedef struct packed {
        logic signed [DEF_DW-1:0] re;
        logic signed [DEF_DW-1:0] im;
    } cplx_t;

    // Clamp to the two's complement range of a signed value of 'width' bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Arithmetic shift right with round half-up.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] v,
                                                     input int unsigned shift);
        if (shift == 0) return v;
        return (v + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Handshake and data bundle of the butterfly: input side, output side and sticky flag.
interface butterfly_pipe_if
    import fft_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned TW = DEF_TW
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic                 inv;
    logic                 scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] xr, xi, yr, yi;
    logic                 sat_flag;
    logic                 clr_flag;

    modport master (
        output in_valid, ar, ai, br, bi, wr, wi, inv, scale, out_ready, clr_flag,
        input  in_ready, out_valid, xr, xi, yr, yi, sat_flag
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, wr, wi, inv, scale, out_ready, clr_flag,
        output in_ready, out_valid, xr, xi, yr, yi, sat_flag
    );
endinterface

// File: rtl/cmul_pipe.sv
// Two-stage complex multiply P = B*W (or B*conj(W)) with rounding and saturation to DW+1 bits.
// A and scale travel alongside; o_sat reports saturation of valid data advancing this cycle.
module cmul_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned TW    = DEF_TW,
    parameter int unsigned TFRAC = DEF_TFRAC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_adv,
    input  logic                 i_valid,
    input  logic                 i_inv,
    input  logic                 i_scale,
    input  logic signed [DW-1:0] i_ar,
    input  logic signed [DW-1:0] i_ai,
    input  logic signed [DW-1:0] i_br,
    input  logic signed [DW-1:0] i_bi,
    input  logic signed [TW-1:0] i_wr,
    input  logic signed [TW-1:0] i_wi,
    output logic                 o_valid,
    output logic                 o_scale,
    output logic signed [DW-1:0] o_ar,
    output logic signed [DW-1:0] o_ai,
    output logic signed [DW:0]   o_pr,
    output logic signed [DW:0]   o_pi,
    output logic                 o_sat
);
    localparam int unsigned PW = DW + TW;

    logic signed [TW-1:0] w_wi;
    logic                 w_sat1;

    // Negating the most negative twiddle cannot be represented; clamp it.
    always_comb begin
        w_wi   = i_wi;
        w_sat1 = 1'b0;
        if (i_inv) begin
            if (i_wi == {1'b1, {(TW-1){1'b0}}}) begin
                w_wi   = {1'b0, {(TW-1){1'b1}}};
                w_sat1 = 1'b1;
            end else begin
                w_wi = -i_wi;
            end
        end
    end

    logic                 r1_v, r1_scale;
    logic signed [DW-1:0] r1_ar, r1_ai;
    logic signed [PW-1:0] r_prr, r_pii, r_pri, r_pir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_v     <= 1'b0;
            r1_scale <= 1'b0;
            r1_ar    <= '0;
            r1_ai    <= '0;
            r_prr    <= '0;
            r_pii    <= '0;
            r_pri    <= '0;
            r_pir    <= '0;
        end else if (i_adv) begin
            r1_v     <= i_valid;
            r1_scale <= i_scale;
            r1_ar    <= i_ar;
            r1_ai    <= i_ai;
            r_prr    <= PW'(i_br) * PW'(i_wr);
            r_pii    <= PW'(i_bi) * PW'(w_wi);
            r_pri    <= PW'(i_br) * PW'(w_wi);
            r_pir    <= PW'(i_bi) * PW'(i_wr);
        end
    end

    logic signed [PW:0]   w_pr_sum, w_pi_sum;
    logic signed [63:0]   w_pr_rnd, w_pi_rnd, w_pr_sat, w_pi_sat;
    logic                 w_sat2;

    always_comb begin
        w_pr_sum = (PW+1)'(r_prr) - (PW+1)'(r_pii);
        w_pi_sum = (PW+1)'(r_pri) + (PW+1)'(r_pir);
        w_pr_rnd = round_shr(64'(w_pr_sum), TFRAC);
        w_pi_rnd = round_shr(64'(w_pi_sum), TFRAC);
        w_pr_sat = sat_to(w_pr_rnd, DW + 1);
        w_pi_sat = sat_to(w_pi_rnd, DW + 1);
        w_sat2   = (w_pr_sat != w_pr_rnd) || (w_pi_sat != w_pi_rnd);
    end

    logic                 r2_v, r2_scale;
    logic signed [DW-1:0] r2_ar, r2_ai;
    logic signed [DW:0]   r2_pr, r2_pi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_v     <= 1'b0;
            r2_scale <= 1'b0;
            r2_ar    <= '0;
            r2_ai    <= '0;
            r2_pr    <= '0;
            r2_pi    <= '0;
        end else if (i_adv) begin
            r2_v     <= r1_v;
            r2_scale <= r1_scale;
            r2_ar    <= r1_ar;
            r2_ai    <= r1_ai;
            r2_pr    <= (DW+1)'(w_pr_sat);
            r2_pi    <= (DW+1)'(w_pi_sat);
        end
    end

    assign o_valid = r2_v;
    assign o_scale = r2_scale;
    assign o_ar    = r2_ar;
    assign o_ai    = r2_ai;
    assign o_pr    = r2_pr;
    assign o_pi    = r2_pi;
    assign o_sat   = i_adv && ((w_sat1 && i_valid) || (w_sat2 && r1_v));

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B with optional /2, saturation
// and a sticky overflow flag. One global stall freezes all three stages.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned TW    = DEF_TW,
    parameter int unsigned TFRAC = DEF_TFRAC
) (
    input logic             clk,
    input logic             reset_n,
    butterfly_pipe_if.slave bus
);
    logic                 r3_v;
    logic                 w_adv;
    logic                 w_v2, w_scale2, w_sat12;
    logic signed [DW-1:0] w_ar, w_ai;
    logic signed [DW:0]   w_pr, w_pi;

    assign w_adv        = !r3_v || bus.out_ready;
    assign bus.in_ready = w_adv;

    cmul_pipe #(
        .DW    (DW),
        .TW    (TW),
        .TFRAC (TFRAC)
    ) u_cmul (
        .clk     (clk),
        .reset_n (reset_n),
        .i_adv   (w_adv),
        .i_valid (bus.in_valid),
        .i_inv   (bus.inv),
        .i_scale (bus.scale),
        .i_ar    (bus.ar),
        .i_ai    (bus.ai),
        .i_br    (bus.br),
        .i_bi    (bus.bi),
        .i_wr    (bus.wr),
        .i_wi    (bus.wi),
        .o_valid (w_v2),
        .o_scale (w_scale2),
        .o_ar    (w_ar),
        .o_ai    (w_ai),
        .o_pr    (w_pr),
        .o_pi    (w_pi),
        .o_sat   (w_sat12)
    );

    logic signed [63:0] w_s[4];
    logic signed [63:0] w_c[4];
    logic               w_sat3;

    // Sums fit easily in 64 bits, so scaling and clamping happen in the wide domain.
    always_comb begin
        w_s[0] = 64'(w_ar) + 64'(w_pr);
        w_s[1] = 64'(w_ai) + 64'(w_pi);
        w_s[2] = 64'(w_ar) - 64'(w_pr);
        w_s[3] = 64'(w_ai) - 64'(w_pi);
        w_sat3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w_scale2) w_s[k] = round_shr(w_s[k], 1);
            w_c[k] = sat_to(w_s[k], DW);
            if (w_c[k] != w_s[k]) w_sat3 = 1'b1;
        end
    end

    logic signed [DW-1:0] r_xr, r_xi, r_yr, r_yi;
    logic                 r_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r3_v  <= 1'b0;
            r_xr  <= '0;
            r_xi  <= '0;
            r_yr  <= '0;
            r_yi  <= '0;
            r_sat <= 1'b0;
        end else begin
            if (w_adv) begin
                r3_v <= w_v2;
                if (w_v2) begin
                    r_xr <= DW'(w_c[0]);
                    r_xi <= DW'(w_c[1]);
                    r_yr <= DW'(w_c[2]);
                    r_yi <= DW'(w_c[3]);
                end
            end
            // A new saturation event takes priority over a simultaneous clear.
            if (w_sat12 || (w_sat3 && w_v2 && w_adv)) r_sat <= 1'b1;
            else if (bus.clr_flag)                  r_sat <= 1'b0;
        end
    end

    assign bus.out_valid = r3_v;
    assign bus.xr        = r_xr;
    assign bus.xi        = r_xi;
    assign bus.yr        = r_yr;
    assign bus.yi        = r_yi;
    assign bus.sat_flag  = r_sat;

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, fully pipelined radix-2 DIT butterfly for the FFT datapath. It computes A' = A + W*B and B' = A - W*B in one pass, and accepts one butterfly per cycle under a valid/ready handshake. It replaces the multi-cycle mux/MAC butterfly. New capabilities: per-transaction inverse mode (conjugate twiddle), optional 1/2 scaling with rounding, saturation, and a sticky overflow flag.

Parameters:
DW, 16, data width of each real/imag sample (two's complement)
TW, 16, twiddle width (two's complement)
TFRAC, 8, twiddle fraction bits (1.0 = 1<<TFRAC; default Q8.8, 1.0 = 0x0100)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
ar, ai  in  DW each  A operand real/imag
br, bi  in  DW each  B operand real/imag
wr, wi  in  TW each  twiddle real/imag
inv  in  1  1 = use conj(W) (IFFT)
scale  in  1  1 = divide both outputs by 2 with rounding
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
xr, xi  out  DW each  A' real/imag
yr, yi  out  DW each  B' real/imag
sat_flag  out  1  sticky: any saturation since reset/clear
clr_flag  in  1  synchronous clear of sat_flag

Behaviour:
- Reset: asynchronous, active-low. While reset_n=0: all pipeline valids=0, out_valid=0, xr/xi/yr/yi=0, sat_flag=0. Reset mid-stream discards all in-flight transactions.
- Pipeline: 3 register stages with a global stall. advance = !v3 || out_ready. in_ready = advance (combinational from out_ready; accepted). A transfer occurs when in_valid && in_ready.
- Stalling: when advance=0, every stage holds, and out_* stay stable while out_valid=1. No loss, no duplication, order preserved. Bubbles are not collapsed.
- Latency 3 cycles from accept to out_valid with no stall. Throughput 1 per cycle.
- S1 (register): inv and scale travel with the data. If inv=1, wi is negated; negating -2^(TW-1) saturates to 2^(TW-1)-1 and sets sat. Registers four full-width products br*wr, bi*wi, br*wi, bi*wr (DW+TW bits each).
- S2 (register):
  - pr = br*wr - bi*wi; pi = br*wi + bi*wr (DW+TW+1 bits).
  - Round half-up: add 1<<(TFRAC-1), then arithmetic shift right by TFRAC.
  - Saturate to DW+1 bits; saturation sets sat. A is delayed alongside.
- S3 (output register):
  - sa = A + P, sd = A - P (DW+2 bits).
  - If scale=1: (v + 1) >>> 1 (round half-up).
  - Saturate to [-2^(DW-1), 2^(DW-1)-1] and set sat.
- sat_flag:
  - Set in the cycle after any stage with valid data saturates while advancing.
  - clr_flag=1 clears it. If clear and set happen in the same cycle, set wins.
  - Saturation on stalled or invalid stages is ignored.
- Invalid stage contents do not affect outputs. Output data is undefined-but-stable only when out_valid=0; the implementation holds the last value.

Decomposition:
- Package fft_pkg holds:
  - defaults DW/TW/TFRAC;
  - constant ONE_Q = 1<<TFRAC;
  - functions sat_to(width) and round_shr(value, shift) (half-up);
  - the complex sample struct typedef (re/im).
- One natural sub-module: cmul_pipe (stages S1–S2: conjugate, 4 multipliers, combine, round, saturate, with valid and stall inputs). The top holds S3, the handshake and sat_flag.

Test Plan:
- Identity: A=(0x0100,0), B=(0x0100,0), W=(0x0100,0), inv=0, scale=0 -> X=(0x0200,0), Y=(0,0), out_valid exactly 3 cycles after accept, sat_flag=0.
- Twiddle -j and inverse:
  - A=(0,0), B=(0x0100,0), W=(0,0xFF00), inv=0 -> X=(0,0xFF00), Y=(0,0x0100).
  - Same with inv=1 -> X=(0,0x0100), Y=(0,0xFF00).
- Saturation/scale:
  - A=B=(0x7F00,0), W=ONE, scale=0 -> X=(0x7FFF,0), sat_flag=1 next cycle.
  - clr_flag, then the same with scale=1 -> X=(0x7F00,0), Y=(0,0), sat_flag stays 0.
- Rounding: scale=1, A=(0x0001,0), B=(0x0002,0), W=ONE -> X=(0x0002,0) (3 → 2), Y=(0,0) (-1 → 0).
- Backpressure: 6 back-to-back inputs with out_ready=0 for cycles 4–8 -> in_ready low while stalled, held output stable, all 6 outputs delivered in order, none dropped or repeated.
- Reset mid-stream: reset_n low for 1 cycle with 3 in flight -> outputs and out_valid immediately 0, sat_flag 0, none of the 3 emerge; the next input returns after 3 cycles.
